// File: rtl/cp0_regfile_pkg.sv
// Shared pipeline defines: control-signal constants plus the CP0 register map,
// field positions, committed excepttype codes and Cause.ExcCode values.
package cp0_regfile_pkg;

  localparam int          WORD_W       = 32;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
  localparam logic        WRITE_ENABLE = 1'b1;

  // CP0 register numbers
  localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_REG_COUNT    = 5'd9;
  localparam logic [4:0] CP0_REG_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_REG_EPC      = 5'd14;

  // Field positions and MTC0 write masks
  localparam int          STATUS_EXL_BIT = 1;
  localparam logic [31:0] STATUS_RESET   = 32'h0040_0000;
  localparam logic [31:0] STATUS_WMASK   = 32'h0000_FF03;
  localparam int          CAUSE_BD_BIT   = 31;
  localparam int          CAUSE_TI_BIT   = 30;
  localparam int          CAUSE_HWIP_LSB = 10;
  localparam int          CAUSE_EXC_LSB  = 2;
  localparam logic [31:0] CAUSE_WMASK    = 32'h0000_0300;

  // Committed excepttype codes from the memory stage (0 = no event)
  localparam logic [31:0] EXCTYPE_INT  = 32'h0000_0001;
  localparam logic [31:0] EXCTYPE_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXCTYPE_ADES = 32'h0000_0005;
  localparam logic [31:0] EXCTYPE_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXCTYPE_BP   = 32'h0000_0009;
  localparam logic [31:0] EXCTYPE_RI   = 32'h0000_000A;
  localparam logic [31:0] EXCTYPE_OV   = 32'h0000_000C;
  localparam logic [31:0] EXCTYPE_ERET = 32'h0000_000E;

  // Cause.ExcCode values
  localparam logic [4:0] EXCCODE_INT  = 5'h00;
  localparam logic [4:0] EXCCODE_ADEL = 5'h04;
  localparam logic [4:0] EXCCODE_ADES = 5'h05;
  localparam logic [4:0] EXCCODE_SYS  = 5'h08;
  localparam logic [4:0] EXCCODE_BP   = 5'h09;
  localparam logic [4:0] EXCCODE_RI   = 5'h0A;
  localparam logic [4:0] EXCCODE_OV   = 5'h0C;

  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_EXC  = 2'd1,
    EV_ERET = 2'd2
  } cp0_event_e;

  typedef struct packed {
    cp0_event_e kind;
    logic [4:0] exc_code;
    logic       load_badvaddr;
  } cp0_event_t;

  // Unknown nonzero codes decode to EV_NONE so they behave like an idle cycle.
  function automatic cp0_event_t decode_event(input logic [31:0] excepttype);
    cp0_event_t ev;
    ev.kind          = EV_NONE;
    ev.exc_code      = EXCCODE_INT;
    ev.load_badvaddr = 1'b0;
    case (excepttype)
      EXCTYPE_INT:  begin ev.kind = EV_EXC; ev.exc_code = EXCCODE_INT; end
      EXCTYPE_ADEL: begin ev.kind = EV_EXC; ev.exc_code = EXCCODE_ADEL; ev.load_badvaddr = 1'b1; end
      EXCTYPE_ADES: begin ev.kind = EV_EXC; ev.exc_code = EXCCODE_ADES; ev.load_badvaddr = 1'b1; end
      EXCTYPE_SYS:  begin ev.kind = EV_EXC; ev.exc_code = EXCCODE_SYS; end
      EXCTYPE_BP:   begin ev.kind = EV_EXC; ev.exc_code = EXCCODE_BP; end
      EXCTYPE_RI:   begin ev.kind = EV_EXC; ev.exc_code = EXCCODE_RI; end
      EXCTYPE_OV:   begin ev.kind = EV_EXC; ev.exc_code = EXCCODE_OV; end
      EXCTYPE_ERET: ev.kind = EV_ERET;
      default:      ev.kind = EV_NONE;
    endcase
    return ev;
  endfunction

endpackage

// File: rtl/cp0_regfile.sv
// MIPS CP0 register file: Count/Compare timer, Status, Cause, EPC, BadVAddr,
// exception/ERET commit and MTC0/MFC0 access.
module cp0_regfile
  import cp0_regfile_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              we_i,
  input  logic [4:0]        waddr_i,
  input  logic [4:0]        raddr_i,
  input  logic [WORD_W-1:0] data_i,
  input  logic [5:0]        int_i,
  input  logic [WORD_W-1:0] excepttype_i,
  input  logic [WORD_W-1:0] current_inst_addr_i,
  input  logic              is_in_delayslot_i,
  input  logic [WORD_W-1:0] bad_addr_i,
  output logic [WORD_W-1:0] data_o,
  output logic [WORD_W-1:0] count_o,
  output logic [WORD_W-1:0] compare_o,
  output logic [WORD_W-1:0] status_o,
  output logic [WORD_W-1:0] cause_o,
  output logic [WORD_W-1:0] epc_o,
  output logic [WORD_W-1:0] badvaddr_o,
  output logic              timer_int_o
);

  // Handshake: there is no valid/ready pair; every input is sampled on each
  // rising edge, with we_i and a nonzero excepttype_i acting as one-cycle strobes.

  logic [WORD_W-1:0] count_q, compare_q, status_q, cause_q, epc_q, badvaddr_q;
  logic [WORD_W-1:0] cause_d, cause_view, epc_from_pc;
  logic              tick_q, timer_int_q;
  logic              mtc0_en, timer_hit, exc_take, eret_take, exl;
  cp0_event_t        ev;

  assign ev          = decode_event(excepttype_i);
  assign exc_take    = (ev.kind == EV_EXC);
  assign eret_take   = (ev.kind == EV_ERET);
  // A committed exception or ERET discards a same-cycle MTC0 entirely.
  assign mtc0_en     = (we_i == WRITE_ENABLE) && (ev.kind == EV_NONE);
  assign exl         = status_q[STATUS_EXL_BIT];
  assign timer_hit   = (compare_q != ZERO_WORD) && (count_q == compare_q);
  assign epc_from_pc = is_in_delayslot_i ? (current_inst_addr_i - 32'd4) : current_inst_addr_i;

  // Count advances on every other edge; a Count write replaces that cycle's step.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= ZERO_WORD;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= ~tick_q;
      if (mtc0_en && (waddr_i == CP0_REG_COUNT)) begin
        count_q <= data_i;
      end else if (tick_q) begin
        count_q <= count_q + 32'd1;
      end
    end
  end

  // Writing Compare acknowledges the timer interrupt and beats a coincident match.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      compare_q   <= ZERO_WORD;
      timer_int_q <= 1'b0;
    end else if (mtc0_en && (waddr_i == CP0_REG_COMPARE)) begin
      compare_q   <= data_i;
      timer_int_q <= 1'b0;
    end else if (timer_hit) begin
      timer_int_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      status_q <= STATUS_RESET;
    end else if (exc_take) begin
      status_q[STATUS_EXL_BIT] <= 1'b1;
    end else if (eret_take) begin
      status_q[STATUS_EXL_BIT] <= 1'b0;
    end else if (mtc0_en && (waddr_i == CP0_REG_STATUS)) begin
      status_q <= (status_q & ~STATUS_WMASK) | (data_i & STATUS_WMASK);
    end
  end

  // Hardware IP bits track the interrupt lines every cycle; TI is presented live.
  always_comb begin
    cause_d = cause_q;
    cause_d[CAUSE_HWIP_LSB +: 6] = {int_i[5] | timer_int_q, int_i[4:0]};
    if (exc_take) begin
      if (!exl) begin
        cause_d[CAUSE_BD_BIT] = is_in_delayslot_i;
      end
      cause_d[CAUSE_EXC_LSB +: 5] = ev.exc_code;
    end else if (mtc0_en && (waddr_i == CP0_REG_CAUSE)) begin
      cause_d = (cause_d & ~CAUSE_WMASK) | (data_i & CAUSE_WMASK);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cause_q <= ZERO_WORD;
    end else begin
      cause_q <= cause_d;
    end
  end

  // A nested exception (EXL already set) must keep the original return address.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      epc_q <= ZERO_WORD;
    end else if (exc_take) begin
      if (!exl) begin
        epc_q <= epc_from_pc;
      end
    end else if (mtc0_en && (waddr_i == CP0_REG_EPC)) begin
      epc_q <= data_i;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      badvaddr_q <= ZERO_WORD;
    end else if (exc_take && ev.load_badvaddr) begin
      badvaddr_q <= bad_addr_i;
    end
  end

  always_comb begin
    cause_view = cause_q;
    cause_view[CAUSE_TI_BIT] = timer_int_q;
  end

  // MFC0 sees pre-edge state only; forwarding of in-flight MTC0 lives outside.
  always_comb begin
    data_o = ZERO_WORD;
    case (raddr_i)
      CP0_REG_BADVADDR: data_o = badvaddr_q;
      CP0_REG_COUNT:    data_o = count_q;
      CP0_REG_COMPARE:  data_o = compare_q;
      CP0_REG_STATUS:   data_o = status_q;
      CP0_REG_CAUSE:    data_o = cause_view;
      CP0_REG_EPC:      data_o = epc_q;
      default:          data_o = ZERO_WORD;
    endcase
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign status_o    = status_q;
  assign cause_o     = cause_view;
  assign epc_o       = epc_q;
  assign badvaddr_o  = badvaddr_q;
  assign timer_int_o = timer_int_q;

endmodule

// File: doc/cp0_regfile.md
CP0_REGFILE -- requirements
Module: cp0_regfile

Interface
REQ-001 clk  in  1  single system clock; all state updates on rising edge.
REQ-002 resetn  in  1  asynchronous, active-low reset.
REQ-003 we_i  in  1  MTC0 write enable (decoder isWritecp0).
REQ-004 waddr_i  in  5  write register number (decoder writecp0Addr); raddr_i  in  5  read register number (readcp0Addr).
REQ-005 data_i  in  32  MTC0 write data (rt value).
REQ-006 int_i  in  6  external hardware interrupt lines, level-sensitive.
REQ-007 excepttype_i  in  32  committed exception code from memory stage, 0 = none.
REQ-008 current_inst_addr_i  in  32  PC of excepting instruction; is_in_delayslot_i  in  1  instruction in branch delay slot.
REQ-009 bad_addr_i  in  32  faulting address for AdEL/AdES.
REQ-010 data_o  out  32  combinational MFC0 read data for raddr_i.
REQ-011 count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o  out  32 each  current register values.
REQ-012 timer_int_o  out  1  timer interrupt pending.

Function
REQ-013 Implemented registers: BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14); data_o SHALL read 0 for any other number.
REQ-014 Count SHALL increment by 1 every second clk cycle (internal tick toggle), wrapping 0xFFFFFFFF -> 0.
REQ-015 timer_int_o SHALL set when Compare != 0 and Count == Compare, and hold until Compare is written.
REQ-016 MTC0 Count: Count <= data_i, tick toggle unchanged; write overrides increment that cycle.
REQ-017 MTC0 Compare: Compare <= data_i and timer_int_o cleared; clear wins over simultaneous set.
REQ-018 MTC0 Status: only IM[15:8], EXL[1], IE[0] writable; other bits keep value.
REQ-019 MTC0 Cause: only IP[9:8] writable; MTC0 EPC: all 32 bits; MTC0 BadVAddr ignored.
REQ-020 Cause.IP[15:10] SHALL update every cycle to {int_i[5] | timer_int_o, int_i[4:0]}; Cause.TI[30] = timer_int_o.
REQ-021 Exception (excepttype_i nonzero, not ERET): if Status.EXL==0, EPC <= is_in_delayslot_i ? current_inst_addr_i-4 : current_inst_addr_i and Cause.BD[31] <= is_in_delayslot_i; if EXL==1 EPC and BD unchanged.
REQ-022 Exception: Status.EXL <= 1; Cause.ExcCode[6:2] <= code per table: INT 0x00, AdEL 0x04, AdES 0x05, Sys 0x08, Bp 0x09, RI 0x0A, Ov 0x0C.
REQ-023 AdEL/AdES additionally SHALL load BadVAddr <= bad_addr_i.
REQ-024 ERET (excepttype_i = 0x0000000E): Status.EXL <= 0 only; no other register changes.
REQ-025 Exception/ERET and we_i same cycle: exception wins, MTC0 write discarded entirely.
REQ-026 Unknown nonzero excepttype_i: treated as no event.
REQ-027 data_o SHALL reflect register state before the current edge (no write bypass; forwarding is external).

Reset
REQ-028 On resetn low, immediately: Count 0, Compare 0, Cause 0, EPC 0, BadVAddr 0, Status 0x0040_0000 (BEV=1), tick 0, timer_int_o 0.
REQ-029 Reset mid-operation SHALL abort any pending update; first post-reset Count increment on second rising edge after resetn deassertion.

Structure
REQ-030 CP0 register numbers, field bit positions, excepttype codes and ExcCode values SHALL live in the shared defines package, next to existing control-signal defines.
REQ-031 Single flat module; no sub-module required.

Verification
REQ-032 Reset, then 10 cycles idle -> Count == 5, Status == 0x00400000, timer_int_o 0.
REQ-033 MTC0 Compare=0x10, Count=0x0E -> timer_int_o high when Count reaches 0x10, Cause[15]=1, Cause[30]=1; MTC0 Compare=0x100 -> timer_int_o 0 next cycle.
REQ-034 excepttype_i=0x08, PC=0xBFC00100, delayslot=1, EXL=0 -> EPC=0xBFC000FC, Cause.BD=1, ExcCode=0x08, EXL=1.
REQ-035 Second exception 0x0A with EXL=1, PC=0x80000000 -> EPC unchanged, ExcCode=0x0A; then ERET -> EXL=0.
REQ-036 excepttype_i=0x04, bad_addr_i=0x80000003 with we_i=1 to EPC=0x1234 -> BadVAddr=0x80000003, EPC from PC, not 0x1234.
REQ-037 MTC0 Status=0xFFFFFFFF after reset -> Status=0x0040FF03; int_i=6'b000001 -> Cause[10]=1.
